muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_if.sv | 31 +++
 rtl/muldiv_step.sv | 39 +++
 rtl/muldiv_unit.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: ALU op codes
// served by the unit and the controller state encoding.
package muldiv_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] ALU_MUL  = 4'b0101;
  localparam logic [OP_W-1:0] ALU_DIV  = 4'b0110;
  localparam logic [OP_W-1:0] ALU_MULS = 4'b1101;
  localparam logic [OP_W-1:0] ALU_DIVS = 4'b1110;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and muldiv_unit.
//   start, alu_decode, rda, rdx : request (pipeline -> unit)
//   busy, done                  : handshake status (unit -> pipeline)
//   hi, lo, remain              : result registers (unit -> pipeline)
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic [3:0]       alu_decode;
  logic [WIDTH-1:0] rda;
  logic [WIDTH-1:0] rdx;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] remain;

  // Requester side (execute stage).
  modport master (
    output start, alu_decode, rda, rdx,
    input  busy, done, hi, lo, remain
  );

  // Responder side (muldiv_unit).
  modport slave (
    input  start, alu_decode, rda, rdx,
    output busy, done, hi, lo, remain
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath (combinational).
//   div_mode_i : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_i      : MUL {partial product, remaining multiplier bits}
//                DIV {partial remainder, dividend/quotient bits}
//   opnd_i     : multiplicand (MUL) or divisor (DIV)
//   acc_o      : accumulator after this iteration
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               div_mode_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  always_comb begin
    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the carry-extended value right.
    sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Divide: shift in the next dividend bit and trial-subtract. Since the
    // partial remainder is always below the divisor, diff[WIDTH] is the borrow.
    trial = acc_i[2*WIDTH-1:WIDTH-1];
    diff  = trial - {1'b0, opnd_i};
    if (div_mode_i) begin
      if (diff[WIDTH]) begin
        acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
      end else begin
        acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle iterative multiply/divide responder with MIPS-style Hi/Lo.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : muldiv_if.slave (start/alu_decode/rda/rdx in;
//              busy/done/hi/lo/remain out, all registered)
// Optional build macro SIGNED_MULDIV_EN adds MULS/DIVS (signed operands run
// through the unsigned engine as magnitudes, signs fixed up on entry to DONE).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic    clk,
  input logic    rst,
  muldiv_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  muldiv_state_t      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   remain_q, remain_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               is_mul;
  logic               is_div;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               div_mode;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] res;

`ifdef SIGNED_MULDIV_EN
  logic               is_sgn;
  logic               neg_q, neg_d;    // product / quotient negative
  logic               rneg_q, rneg_d;  // remainder negative (dividend sign)
`endif

  // Op decode and operand magnitudes presented to the unsigned engine.
  always_comb begin
    is_mul = (bus.alu_decode == ALU_MUL);
    is_div = (bus.alu_decode == ALU_DIV);
    a_mag  = bus.rda;
    b_mag  = bus.rdx;
`ifdef SIGNED_MULDIV_EN
    is_sgn = (bus.alu_decode == ALU_MULS) || (bus.alu_decode == ALU_DIVS);
    if (bus.alu_decode == ALU_MULS) is_mul = 1'b1;
    if (bus.alu_decode == ALU_DIVS) is_div = 1'b1;
    if (is_sgn && bus.rda[WIDTH-1]) a_mag = -bus.rda;
    if (is_sgn && bus.rdx[WIDTH-1]) b_mag = -bus.rdx;
`endif
  end

  assign div_mode = (state_q == DIV);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode_i (div_mode),
    .acc_i      (acc_q),
    .opnd_i     (opnd_q),
    .acc_o      (step_acc)
  );

  // Next-state, iteration and result-load logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    remain_d = remain_q;
    res      = step_acc;
`ifdef SIGNED_MULDIV_EN
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    if (state_q == MUL) begin
      if (neg_q) res = -step_acc;
    end else begin
      if (neg_q)  res[WIDTH-1:0]       = -step_acc[WIDTH-1:0];
      if (rneg_q) res[2*WIDTH-1:WIDTH] = -step_acc[2*WIDTH-1:WIDTH];
    end
`endif

    case (state_q)
      IDLE: begin
        if (bus.start && (is_mul || is_div)) begin
`ifdef SIGNED_MULDIV_EN
          neg_d  = is_sgn && (bus.rda[WIDTH-1] ^ bus.rdx[WIDTH-1]);
          rneg_d = is_sgn && bus.rda[WIDTH-1];
`endif
          if (is_div && (bus.rdx == '0)) begin
            // Divide by zero resolves without iterating.
            hi_d     = bus.rda;
            lo_d     = '1;
            remain_d = bus.rda;
            state_d  = DONE;
          end else begin
            cnt_d = CNT_W'(WIDTH - 1);
            if (is_mul) begin
              acc_d   = {{WIDTH{1'b0}}, b_mag};
              opnd_d  = a_mag;
              state_d = MUL;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, a_mag};
              opnd_d  = b_mag;
              state_d = DIV;
            end
          end
        end
      end
      MUL: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          hi_d    = res[2*WIDTH-1:WIDTH];
          lo_d    = res[WIDTH-1:0];
          state_d = DONE;
        end
      end
      DIV: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          hi_d     = res[2*WIDTH-1:WIDTH];
          lo_d     = res[WIDTH-1:0];
          remain_d = res[2*WIDTH-1:WIDTH];
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      remain_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SIGNED_MULDIV_EN
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      remain_q <= remain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SIGNED_MULDIV_EN
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
`endif
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.remain = remain_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: expected results are pushed to a
// scoreboard queue when an op is launched and popped when the op has run.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] rem;
    int           lat;
    int           ndone;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           passes = 0;
  logic [W-1:0] mdl_hi  = '0;
  logic [W-1:0] mdl_lo  = '0;
  logic [W-1:0] mdl_rem = '0;

  // Reference model: computes results with native arithmetic.
  task automatic push_expect(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t               e;
    logic [2*W-1:0]     p;
    logic signed [2*W-1:0] sx, sy, sp;
    logic signed [W-1:0]   sa, sbv;
    e.lat   = 0;
    e.ndone = 0;
    case (op)
      ALU_MUL: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        mdl_hi = p[2*W-1:W]; mdl_lo = p[W-1:0];
        e.lat = 33; e.ndone = 1;
      end
      ALU_DIV: begin
        if (b == 0) begin
          mdl_hi = a; mdl_lo = '1; mdl_rem = a; e.lat = 1;
        end else begin
          mdl_lo = a / b; mdl_hi = a % b; mdl_rem = a % b; e.lat = 33;
        end
        e.ndone = 1;
      end
`ifdef SIGNED_MULDIV_EN
      ALU_MULS: begin
        sx = {{W{a[W-1]}}, a}; sy = {{W{b[W-1]}}, b};
        sp = sx * sy;
        mdl_hi = sp[2*W-1:W]; mdl_lo = sp[W-1:0];
        e.lat = 33; e.ndone = 1;
      end
      ALU_DIVS: begin
        if (b == 0) begin
          mdl_hi = a; mdl_lo = '1; mdl_rem = a; e.lat = 1;
        end else begin
          sa = a; sbv = b;
          mdl_lo = sa / sbv; mdl_hi = sa % sbv; mdl_rem = sa % sbv; e.lat = 33;
        end
        e.ndone = 1;
      end
`endif
      default: ;
    endcase
    e.hi = mdl_hi; e.lo = mdl_lo; e.rem = mdl_rem;
    sb.push_back(e);
  endtask

  // Launch one op and observe 40 edges; edge 1 is the accepting edge.
  // Operands are scrambled after acceptance; inj>0 pulses an extra DIV start.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj, output int lat, output int ndone, output int nbusy,
                        output logic [3*W-1:0] res);
    lat = 0; ndone = 0; nbusy = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.alu_decode = op; bus.rda = a; bus.rdx = b;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (bus.busy) nbusy++;
      if (bus.done) begin
        ndone++;
        if (lat == 0) lat = e;
      end
      bus.rda = $urandom; bus.rdx = $urandom;
      if (e == inj) begin
        bus.start = 1'b1; bus.alu_decode = ALU_DIV; bus.rda = 100; bus.rdx = 7;
      end else begin
        bus.start = 1'b0;
      end
    end
    res = {bus.hi, bus.lo, bus.remain};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.alu_decode = '0; bus.rda = '0; bus.rdx = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) $display("FAIL reset busy/done: got %b want 00", {bus.busy, bus.done});
    else passes++;
    checks++;
    if ({bus.hi, bus.lo, bus.remain} !== '0) $display("FAIL reset hi/lo/remain: got %h want 0", {bus.hi, bus.lo, bus.remain});
    else passes++;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) $display("FAIL idle after reset busy/done: got %b want 00", {bus.busy, bus.done});
    else passes++;
  endtask

  task automatic test_mul();
    logic [W-1:0] ta[4], tb[4];
    int lat, nd, nb; logic [3*W-1:0] res; exp_t e;
    ta = '{32'd5, 32'hFFFFFFFF, 32'd0, $urandom};
    tb = '{32'd3, 32'hFFFFFFFF, $urandom, $urandom};
    for (int i = 0; i < 4; i++) begin
      push_expect(ALU_MUL, ta[i], tb[i]);
      run_op(ALU_MUL, ta[i], tb[i], 0, lat, nd, nb, res);
      e = sb.pop_front();
      checks++; if (lat !== e.lat) $display("FAIL mul%0d latency: got %0d want %0d", i, lat, e.lat); else passes++;
      checks++; if (nd !== e.ndone) $display("FAIL mul%0d done pulses: got %0d want %0d", i, nd, e.ndone); else passes++;
      checks++; if (nb !== e.lat) $display("FAIL mul%0d busy cycles: got %0d want %0d", i, nb, e.lat); else passes++;
      checks++; if (res !== {e.hi, e.lo, e.rem})
        $display("FAIL mul%0d hi/lo/remain: got %h want %h", i, res, {e.hi, e.lo, e.rem}); else passes++;
    end
  endtask

  task automatic test_div();
    logic [W-1:0] ta[5], tb[5];
    int lat, nd, nb; logic [3*W-1:0] res; exp_t e;
    ta = '{32'd10, 32'd7, 32'd100, $urandom, 32'd0};
    tb = '{32'd2, 32'd0, 32'd7, 32'($urandom_range(1, 5000)), 32'd5};
    for (int i = 0; i < 5; i++) begin
      push_expect(ALU_DIV, ta[i], tb[i]);
      run_op(ALU_DIV, ta[i], tb[i], 0, lat, nd, nb, res);
      e = sb.pop_front();
      checks++; if (lat !== e.lat) $display("FAIL div%0d latency: got %0d want %0d", i, lat, e.lat); else passes++;
      checks++; if (nd !== e.ndone) $display("FAIL div%0d done pulses: got %0d want %0d", i, nd, e.ndone); else passes++;
      checks++; if (nb !== e.lat) $display("FAIL div%0d busy cycles: got %0d want %0d", i, nb, e.lat); else passes++;
      checks++; if (res !== {e.hi, e.lo, e.rem})
        $display("FAIL div%0d hi/lo/remain: got %h want %h", i, res, {e.hi, e.lo, e.rem}); else passes++;
    end
  endtask

  task automatic test_unsupported();
    logic [3:0] ops[3];
    int lat, nd, nb; logic [3*W-1:0] res; exp_t e;
    ops = '{4'b0000, 4'b0111, 4'b0100};
    for (int i = 0; i < 3; i++) begin
      push_expect(ops[i], 32'd9, 32'd4);
      run_op(ops[i], 32'd9, 32'd4, 0, lat, nd, nb, res);
      e = sb.pop_front();
      checks++; if (nd !== e.ndone) $display("FAIL unsup%0d done pulses: got %0d want %0d", i, nd, e.ndone); else passes++;
      checks++; if (nb !== e.lat) $display("FAIL unsup%0d busy cycles: got %0d want %0d", i, nb, e.lat); else passes++;
      checks++; if (res !== {e.hi, e.lo, e.rem})
        $display("FAIL unsup%0d hi/lo/remain: got %h want %h", i, res, {e.hi, e.lo, e.rem}); else passes++;
    end
  endtask

  // Extra start pulses mid-op, during DONE (no back-to-back), and during a
  // divide-by-zero DONE cycle must all be ignored.
  task automatic test_start_while_busy();
    logic [3:0] ops[3]; logic [W-1:0] ta[3], tb[3]; int inj[3];
    int lat, nd, nb; logic [3*W-1:0] res; exp_t e;
    ops = '{ALU_MUL, ALU_MUL, ALU_DIV};
    ta  = '{32'd5, 32'd6, 32'd9};
    tb  = '{32'd3, 32'd7, 32'd0};
    inj = '{10, 33, 1};
    for (int i = 0; i < 3; i++) begin
      push_expect(ops[i], ta[i], tb[i]);
      run_op(ops[i], ta[i], tb[i], inj[i], lat, nd, nb, res);
      e = sb.pop_front();
      checks++; if (lat !== e.lat) $display("FAIL busy_start%0d latency: got %0d want %0d", i, lat, e.lat); else passes++;
      checks++; if (nd !== e.ndone) $display("FAIL busy_start%0d done pulses: got %0d want %0d", i, nd, e.ndone); else passes++;
      checks++; if (nb !== e.lat) $display("FAIL busy_start%0d busy cycles: got %0d want %0d", i, nb, e.lat); else passes++;
      checks++; if (res !== {e.hi, e.lo, e.rem})
        $display("FAIL busy_start%0d hi/lo/remain: got %h want %h", i, res, {e.hi, e.lo, e.rem}); else passes++;
    end
  endtask

  task automatic test_rst_mid();
    int lat, nd, nb; logic [3*W-1:0] res; exp_t e;
    @(negedge clk);
    bus.start = 1'b1; bus.alu_decode = ALU_DIV; bus.rda = 100; bus.rdx = 7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b1) $display("FAIL rst_mid busy before reset: got %b want 1", bus.busy); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.busy, bus.done} !== 2'b00) $display("FAIL rst_mid busy/done: got %b want 00", {bus.busy, bus.done}); else passes++;
    checks++; if ({bus.hi, bus.lo, bus.remain} !== '0)
      $display("FAIL rst_mid hi/lo/remain: got %h want 0", {bus.hi, bus.lo, bus.remain}); else passes++;
    mdl_hi = '0; mdl_lo = '0; mdl_rem = '0;
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) $display("FAIL rst_mid done while held: got %b want 0", bus.done); else passes++;
    @(negedge clk); rst = 1'b0;
    push_expect(ALU_DIV, 32'd100, 32'd7);
    run_op(ALU_DIV, 32'd100, 32'd7, 0, lat, nd, nb, res);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) $display("FAIL rst_mid rerun latency: got %0d want %0d", lat, e.lat); else passes++;
    checks++; if (nd !== e.ndone) $display("FAIL rst_mid rerun done pulses: got %0d want %0d", nd, e.ndone); else passes++;
    checks++; if (res !== {e.hi, e.lo, e.rem})
      $display("FAIL rst_mid rerun hi/lo/remain: got %h want %h", res, {e.hi, e.lo, e.rem}); else passes++;
  endtask

  // Signed ops: results when the option is built in, ignored otherwise.
  task automatic test_signed();
    logic [3:0] ops[4]; logic [W-1:0] ta[4], tb[4];
    int lat, nd, nb; logic [3*W-1:0] res; exp_t e;
    ops = '{ALU_DIVS, ALU_MULS, ALU_DIVS, ALU_MULS};
    ta  = '{-32'sd7, -32'sd5, -32'sd9, 32'd4};
    tb  = '{32'd2, 32'd3, 32'd0, -32'sd6};
    for (int i = 0; i < 4; i++) begin
      push_expect(ops[i], ta[i], tb[i]);
      run_op(ops[i], ta[i], tb[i], 0, lat, nd, nb, res);
      e = sb.pop_front();
      checks++; if (lat !== e.lat) $display("FAIL signed%0d latency: got %0d want %0d", i, lat, e.lat); else passes++;
      checks++; if (nd !== e.ndone) $display("FAIL signed%0d done pulses: got %0d want %0d", i, nd, e.ndone); else passes++;
      checks++; if (nb !== e.lat) $display("FAIL signed%0d busy cycles: got %0d want %0d", i, nb, e.lat); else passes++;
      checks++; if (res !== {e.hi, e.lo, e.rem})
        $display("FAIL signed%0d hi/lo/remain: got %h want %h", i, res, {e.hi, e.lo, e.rem}); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_unsupported();
    test_start_while_busy();
    test_rst_mid();
    test_signed();
    checks++;
    if (sb.size() !== 0) $display("FAIL scoreboard drained: got %0d entries want 0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
